// File: rtl/generador_pulso.sv
// Programmable pulse generator: a start request emits `periodo` high cycles followed by a
// `pausa` low gap, once or continuously until stop. All outputs are registered.
module generador_pulso #(
  parameter int BIT_periodo = 4,
  parameter int BIT_pausa   = 8,
  parameter int BIT_npulsos = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIT_periodo-1:0] periodo,
  input  logic [BIT_pausa-1:0]   pausa,
  input  logic                   continuo,
  input  logic                   stop,
  output logic                   pulso,
  output logic                   busy,
  output logic                   done,
  output logic [BIT_npulsos-1:0] npulsos,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 r_state, w_state;
  logic [BIT_periodo-1:0] r_per, w_per;
  logic [BIT_pausa-1:0]   r_pau, w_pau;
  logic                   r_cont, w_cont;
  logic [BIT_periodo-1:0] r_hcnt, w_hcnt;
  logic [BIT_pausa-1:0]   r_gcnt, w_gcnt;
  logic                   r_pulso, w_pulso;
  logic                   r_busy, w_busy;
  logic                   r_done, w_done;
  logic [BIT_npulsos-1:0] r_npulsos, w_npulsos;
  logic [BIT_pausa-1:0]   w_gap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_per     <= '0;
      r_pau     <= '0;
      r_cont    <= 1'b0;
      r_hcnt    <= '0;
      r_gcnt    <= '0;
      r_pulso   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_npulsos <= '0;
    end else begin
      r_state   <= w_state;
      r_per     <= w_per;
      r_pau     <= w_pau;
      r_cont    <= w_cont;
      r_hcnt    <= w_hcnt;
      r_gcnt    <= w_gcnt;
      r_pulso   <= w_pulso;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_npulsos <= w_npulsos;
    end
  end

  // Continuous mode needs at least one low cycle so consecutive pulses stay separable.
  assign w_gap = (r_cont && (r_pau == '0)) ? BIT_pausa'(1) : r_pau;

  // start is only looked at in IDLE; stop only outside IDLE and wins over phase completion.
  always_comb begin
    w_state   = r_state;
    w_per     = r_per;
    w_pau     = r_pau;
    w_cont    = r_cont;
    w_hcnt    = r_hcnt;
    w_gcnt    = r_gcnt;
    w_pulso   = r_pulso;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_npulsos = r_npulsos;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_npulsos = '0;
          if (periodo != '0) begin
            w_per   = periodo;
            w_pau   = pausa;
            w_cont  = continuo;
            w_hcnt  = BIT_periodo'(1);
            w_pulso = 1'b1;
            w_busy  = 1'b1;
            w_state = HIGH;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          w_state = IDLE;
          w_pulso = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else if (r_hcnt == r_per) begin
          w_pulso   = 1'b0;
          w_npulsos = r_npulsos + BIT_npulsos'(1);
          if (!r_cont && (r_pau == '0)) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_gcnt  = BIT_pausa'(1);
            w_state = GAP;
          end
        end else begin
          w_hcnt = r_hcnt + BIT_periodo'(1);
        end
      end
      GAP: begin
        if (stop) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else if (r_gcnt == w_gap) begin
          if (r_cont) begin
            w_hcnt  = BIT_periodo'(1);
            w_pulso = 1'b1;
            w_state = HIGH;
          end else begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end else begin
          w_gcnt = r_gcnt + BIT_pausa'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_pulso = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign pulso       = r_pulso;
  assign busy        = r_busy;
  assign done        = r_done;
  assign npulsos     = r_npulsos;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_generador_pulso.sv
// Directed bench for generador_pulso: reset, single, max-width, continuous, abort,
// zero-width and start/stop-collision sequences with hand-computed expectations.
module tb_generador_pulso;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] periodo;
  logic [7:0] pausa;
  logic       continuo;
  logic       stop;
  logic       pulso;
  logic       busy;
  logic       done;
  logic [7:0] npulsos;
  logic [1:0] dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  generador_pulso #(.BIT_periodo(4), .BIT_pausa(8), .BIT_npulsos(8)) dut (
    .clk(clk), .rst(rst), .start(start), .periodo(periodo), .pausa(pausa),
    .continuo(continuo), .stop(stop), .pulso(pulso), .busy(busy), .done(done),
    .npulsos(npulsos), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Issue a one-cycle start; returns at the first sample after the accepting edge.
  task automatic do_start(input int p, input int g, input bit c);
    periodo  = 4'(p);
    pausa    = 8'(g);
    continuo = c;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Counts consecutive high cycles; returns at the first low sample.
  task automatic measure_high(output int cnt);
    cnt = 0;
    while (pulso && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic measure_low(output int cnt);
    cnt = 0;
    while (!pulso && !done && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; periodo = '0; pausa = '0; continuo = 1'b0; stop = 1'b0;
    tick(); tick(); tick();
    chk("rst_pulso", pulso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_npulsos", npulsos, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();

    // Single, P=5 G=3
    do_start(5, 3, 1'b0);
    chk("s5_rise", pulso, 1);
    chk("s5_busy", busy, 1);
    measure_high(n);
    chk("s5_width", n, 5);
    chk("s5_busy_in_gap", busy, 1);
    chk("s5_npulsos", npulsos, 1);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("s5_done_delay", n, 3);
    chk("s5_busy_end", busy, 0);
    chk("s5_pulso_end", pulso, 0);
    tick();
    chk("s5_done_once", done, 0);

    // Single, P=15 G=0: done on the falling edge
    do_start(15, 0, 1'b0);
    measure_high(n);
    chk("s15_width", n, 15);
    chk("s15_done", done, 1);
    chk("s15_busy", busy, 0);
    chk("s15_npulsos", npulsos, 1);
    tick();
    chk("s15_done_once", done, 0);
    chk("s15_no_glitch", pulso, 0);

    // Continuous, P=2 G=0: 2 high / 1 low, stop after 7 pulses
    do_start(2, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      measure_high(n);
      chk($sformatf("c2_width%0d", i), n, 2);
      if (i < 6) begin
        measure_low(n);
        chk($sformatf("c2_gap%0d", i), n, 1);
      end
    end
    chk("c2_busy_run", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c2_stop_done", done, 1);
    chk("c2_stop_pulso", pulso, 0);
    chk("c2_stop_busy", busy, 0);
    chk("c2_npulsos", npulsos, 7);
    tick();
    chk("c2_done_once", done, 0);
    chk("c2_idle", pulso, 0);

    // Abort P=10 at 4th high cycle; start with P=3 while busy is ignored
    do_start(10, 4, 1'b0);
    periodo = 4'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    chk("ab_ignore_start", pulso, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ab_pulso", pulso, 0);
    chk("ab_done", done, 1);
    chk("ab_busy", busy, 0);
    chk("ab_npulsos", npulsos, 0);
    tick();
    chk("ab_done_once", done, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_ignored", done, 0);

    // P=0 start: only a done strobe
    do_start(0, 5, 1'b0);
    chk("z_pulso", pulso, 0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    tick();
    chk("z_done_once", done, 0);
    chk("z_pulso2", pulso, 0);

    // start and stop together in IDLE: start wins
    stop = 1'b1;
    do_start(2, 0, 1'b0);
    stop = 1'b0;
    chk("ss_pulso", pulso, 1);
    chk("ss_busy", busy, 1);
    measure_high(n);
    chk("ss_width", n, 2);
    chk("ss_done", done, 1);

    // Reset mid-HIGH, P=9
    tick();
    do_start(9, 2, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rm_pulso", pulso, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_npulsos", npulsos, 0);
    tick();
    chk("rm_no_strobe", done, 0);
    chk("rm_state", dbg_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/generador_pulso.md
# generador_pulso

- Programmable pulse generator: on `start`, drives `pulso` high for exactly `periodo` clock cycles, then low for `pausa` cycles.
- In continuous mode it repeats until stopped.
- It is the source side of the enable-width measurement path. Its `pulso` output drives the cycle counter (`contador`) enable in self-test and in timed actuator/sensor trigger paths.
- A width programmed here must read back as the same value at the counter.

## Interface
- `BIT_periodo`, 4 — width of the high-time count.
- `BIT_pausa`, 8 — width of the low-time (gap) count.
- `BIT_npulsos`, 8 — width of the emitted-pulse counter.
- `clk` in 1 — single clock; all logic on posedge.
- `rst` in 1 — reset, synchronous, active-low.
- `start` in 1 — request; sampled only in IDLE.
- `periodo` in BIT_periodo — high time in cycles; latched at accepted start.
- `pausa` in BIT_pausa — low time between pulses; latched at accepted start.
- `continuo` in 1 — 1 = repeat until `stop`; latched at accepted start.
- `stop` in 1 — abort or end of sequence; sampled in every non-IDLE state.
- `pulso` out 1 — generated pulse; registered.
- `busy` out 1 — high from accepted start until return to IDLE.
- `done` out 1 — one-cycle strobe when a sequence ends.
- `npulsos` out BIT_npulsos — count of completed high phases since the last accepted start.

## Operation
- Reset (`rst`=0 at a posedge): state=IDLE, `pulso`=0, `busy`=0, `done`=0, `npulsos`=0, internal counters=0. Reset overrides all inputs, including mid-pulse.
- States are IDLE, HIGH and GAP.
- **IDLE**
  - `start`=1 with `periodo`≠0: latch `periodo`/`pausa`/`continuo`, clear `npulsos`, go to HIGH, `busy`=1, `pulso`=1.
  - `start`=1 with `periodo`=0: no pulse; `done`=1 for one cycle, `busy` stays 0, `npulsos` cleared.
- **HIGH**
  - `pulso`=1; a cycle counter runs 1..periodo_l.
  - On the cycle where the count equals periodo_l: `pulso`→0 and `npulsos` increments (wraps modulo 2^BIT_npulsos).
  - Then go to GAP, or end the sequence if the gap is skipped.
- **GAP**
  - `pulso`=0 for pausa_l cycles.
  - In single mode with pausa_l=0, GAP is skipped.
  - In continuous mode with pausa_l=0, the effective gap is 1 cycle, so pulses stay distinguishable.
  - At the end of GAP:
    - continuo_l=1: return to HIGH.
    - Otherwise: end the sequence.
- **End of sequence:** `done`=1 for exactly one cycle, `busy`→0, go to IDLE.
- **`stop`=1 in HIGH or GAP:** on the next edge, `pulso`=0, `done`=1, `busy`=0, go to IDLE.
  - A truncated high phase does not increment `npulsos`.
  - `stop` in IDLE is ignored.
- `start` while `busy` is ignored. New `periodo`/`pausa` values take effect only at the next accepted start.
- `stop` and `start` in the same IDLE cycle: start wins (stop is not sampled in IDLE).
- `done` is 0 in every cycle except the strobe cycle. `done` and `pulso` are never 1 in the same cycle.

## Timing
- Let `start` be sampled at edge k with periodo=P, pausa=G.
- `pulso` rises at edge k+1 and falls at edge k+1+P: exactly P cycles high.
- Single mode, G≥1: `done` high during the cycle after edge k+1+P+G; `busy` falls at that same edge.
- Single mode, G=0: `done` asserted at edge k+1+P, the same edge `pulso` falls.
- Continuous mode: the period is P+max(G,1) cycles. Rising edges occur at k+1+n·(P+max(G,1)).
- `stop` sampled at edge s: `pulso`=0 and `done`=1 from edge s+1; IDLE from edge s+1. `done` falls at edge s+2.
- Earliest restart: `start` is accepted at the edge where `done` falls. Back-to-back single pulses are therefore separated by at least G+1 low cycles.
- Maximum high time: 2^BIT_periodo−1 cycles. The counter must not overflow at P=all-ones.

## Test plan
- Reset mid-HIGH (P=9, `rst`=0 at edge 4): the following edge gives `pulso`=0, `busy`=0, `done`=0, `npulsos`=0; no `done` strobe.
- Single, P=5, G=3: `pulso` high 5 cycles; `done` strobe 3 cycles after the fall; `npulsos`=1. Looping `pulso` into `contador` enable reads back `periodo`=5.
- Single, P=15 (max, BIT_periodo=4), G=0: 15 high cycles; `done` on the falling edge cycle; no wrap glitch.
- Continuous, P=2, G=0, `stop` after 7 pulses: period 3 cycles (2 high, 1 low); `npulsos`=7; one `done` one cycle after `stop`.
- Abort: P=10, `stop` at the 4th high cycle: `pulso` low next edge, `done`=1, `npulsos`=0. A `start` during busy with P=3 produces no effect.
- P=0 `start`: `pulso` stays 0, `done` strobes one cycle, `busy` stays 0.
